// File: rtl/vec_wb_sequencer.sv
// Vector register-file write-back sequencer: takes one LMUL-grouped (or v0 mask)
// request, validates the destination group, then issues one register write per cycle.
module vec_wb_sequencer #(
  parameter int unsigned VLEN       = 512,
  parameter int unsigned MAX_VLEN   = 4096,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [REG_ADDR_W-1:0] req_waddr,
  input  logic [3:0]            req_lmul,
  input  logic [MAX_VLEN-1:0]   req_wdata,
  input  logic                  req_mask,
  input  logic                  stall,
  output logic                  rf_wr_en,
  output logic                  rf_mask_wr_en,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [VLEN-1:0]       rf_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  wrong_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_MASK,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [REG_ADDR_W-1:0] r_base;
  logic [3:0]            r_lmul;
  logic [3:0]            r_cnt;
  logic                  r_mask;
  logic [MAX_VLEN-1:0]   r_data;

  logic                  w_hs;
  logic                  w_active;
  logic                  w_pow2;
  logic                  w_align;
  logic                  w_fits;
  logic                  w_ok;
  logic [REG_ADDR_W-1:0] w_lmul_mask;
  logic [REG_ADDR_W:0]   w_end;
  logic                  w_issue;
  logic                  w_src_mask;
  logic [REG_ADDR_W-1:0] w_src_base;
  logic [3:0]            w_src_cnt;
  logic [MAX_VLEN-1:0]   w_src_data;
  logic [VLEN-1:0]       w_slice;
  logic                  w_wr_en_d;
  logic                  w_mask_en_d;
  logic [REG_ADDR_W-1:0] w_waddr_d;
  logic [VLEN-1:0]       w_wdata_d;
  logic                  w_done_d;
  logic                  w_err_d;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = w_active;
  assign w_active  = (r_state == S_WRITE) || (r_state == S_MASK);
  assign w_hs      = req_valid && req_ready;

  // Group legality: power-of-two size, naturally aligned, and no wrap past the last register.
  assign w_pow2      = (req_lmul == 4'd1) || (req_lmul == 4'd2) ||
                       (req_lmul == 4'd4) || (req_lmul == 4'd8);
  assign w_lmul_mask = REG_ADDR_W'(req_lmul - 4'd1);
  assign w_align     = (req_waddr & w_lmul_mask) == '0;
  assign w_end       = {1'b0, req_waddr} + (REG_ADDR_W+1)'(req_lmul);
  assign w_fits      = w_end <= (REG_ADDR_W+1)'(NUM_REGS);
  assign w_ok        = req_mask ? (req_waddr == '0) : (w_pow2 && w_align && w_fits);

  // Registered rf outputs are loaded from the beat about to be issued, so the first
  // beat is sourced straight from the request on the handshake edge.
  assign w_src_mask = w_hs ? req_mask  : r_mask;
  assign w_src_base = w_hs ? (req_mask ? '0 : req_waddr) : r_base;
  assign w_src_cnt  = w_hs ? 4'd0      : r_cnt;
  assign w_src_data = w_hs ? req_wdata : r_data;
  assign w_issue    = !stall && ((w_hs && w_ok) || (w_active && (r_cnt < r_lmul)));

  always_comb begin
    w_slice = '0;
    for (int unsigned k = 0; k < MAX_VLEN / VLEN; k++) begin
      if (w_src_cnt == k[3:0]) begin
        w_slice = w_src_data[k*VLEN +: VLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_lmul  <= '0;
      r_cnt   <= '0;
      r_mask  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_base <= req_mask ? '0 : req_waddr;
        r_lmul <= req_mask ? 4'd1 : req_lmul;
        r_mask <= req_mask;
        r_data <= req_wdata;
        r_cnt  <= w_issue ? 4'd1 : 4'd0;
      end else if (w_active && w_issue) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (!w_ok) begin
            w_next = S_ERR;
          end else if (req_mask) begin
            w_next = S_MASK;
          end else begin
            w_next = S_WRITE;
          end
        end
      end
      S_WRITE, S_MASK: begin
        if (r_cnt == r_lmul) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en_d   = w_issue && !w_src_mask;
    w_mask_en_d = w_issue && w_src_mask;
    w_waddr_d   = '0;
    w_wdata_d   = '0;
    if (w_issue) begin
      w_waddr_d = w_src_base + REG_ADDR_W'(w_src_cnt);
      w_wdata_d = w_slice;
    end
    w_done_d = w_active && (r_cnt == r_lmul);
    w_err_d  = w_hs && !w_ok;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wr_en      <= 1'b0;
      rf_mask_wr_en <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      done          <= 1'b0;
      wrong_addr    <= 1'b0;
    end else begin
      rf_wr_en      <= w_wr_en_d;
      rf_mask_wr_en <= w_mask_en_d;
      rf_waddr      <= w_waddr_d;
      rf_wdata      <= w_wdata_d;
      done          <= w_done_d;
      wrong_addr    <= w_err_d;
    end
  end

endmodule

// File: tb/tb_vec_wb_sequencer.sv
// Self-checking bench for vec_wb_sequencer: directed cases plus randomized requests
// checked cycle by cycle against a schedule derived from the write-back rules.
module tb_vec_wb_sequencer;
  localparam int unsigned VLEN       = 512;
  localparam int unsigned MAX_VLEN   = 4096;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int          MAXC       = 80;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [REG_ADDR_W-1:0] req_waddr;
  logic [3:0]            req_lmul;
  logic [MAX_VLEN-1:0]   req_wdata;
  logic                  req_mask;
  logic                  stall;
  logic                  rf_wr_en;
  logic                  rf_mask_wr_en;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [VLEN-1:0]       rf_wdata;
  logic                  busy;
  logic                  done;
  logic                  wrong_addr;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  vec_wb_sequencer #(
    .VLEN      (VLEN),
    .MAX_VLEN  (MAX_VLEN),
    .NUM_REGS  (NUM_REGS),
    .REG_ADDR_W(REG_ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_waddr    (req_waddr),
    .req_lmul     (req_lmul),
    .req_wdata    (req_wdata),
    .req_mask     (req_mask),
    .stall        (stall),
    .rf_wr_en     (rf_wr_en),
    .rf_mask_wr_en(rf_mask_wr_en),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy         (busy),
    .done         (done),
    .wrong_addr   (wrong_addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [MAX_VLEN-1:0] rnd_data();
    logic [MAX_VLEN-1:0] r;
    for (int i = 0; i < int'(MAX_VLEN / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_quiet(input string tag, input logic exp_ready);
    check_eq({tag, " rdy"},  VLEN'(req_ready), VLEN'(exp_ready));
    check_eq({tag, " wr"},   VLEN'(rf_wr_en), '0);
    check_eq({tag, " mwr"},  VLEN'(rf_mask_wr_en), '0);
    check_eq({tag, " addr"}, VLEN'(rf_waddr), '0);
    check_eq({tag, " data"}, rf_wdata, '0);
    check_eq({tag, " busy"}, VLEN'(busy), '0);
    check_eq({tag, " done"}, VLEN'(done), '0);
    check_eq({tag, " err"},  VLEN'(wrong_addr), '0);
  endtask

  // Called at a cycle where req_ready is expected high; st[e] is the stall level
  // applied at edge e counted from the handshake edge (e=0).
  task automatic run_req(input logic [REG_ADDR_W-1:0] a, input logic [3:0] l, input logic m,
                         input logic [MAX_VLEN-1:0] d, input logic [63:0] st);
    logic                  exp_wr  [MAXC];
    logic                  exp_mk  [MAXC];
    logic                  exp_dn  [MAXC];
    logic                  exp_er  [MAXC];
    logic                  exp_bz  [MAXC];
    logic                  exp_rdy [MAXC];
    logic [REG_ADDR_W-1:0] exp_a   [MAXC];
    logic [VLEN-1:0]       exp_d   [MAXC];
    bit valid;
    int n, e, issued, last;
    for (int c = 0; c < MAXC; c++) begin
      exp_wr[c] = 0; exp_mk[c] = 0; exp_dn[c] = 0; exp_er[c] = 0;
      exp_bz[c] = 0; exp_rdy[c] = 0; exp_a[c] = '0; exp_d[c] = '0;
    end
    if (m) valid = (a == 0);
    else   valid = (l == 1 || l == 2 || l == 4 || l == 8) &&
                   (int'(a) % int'(l) == 0) && (int'(a) + int'(l) <= int'(NUM_REGS));
    if (!valid) begin
      exp_er[1] = 1;
      last = 2;
    end else begin
      n = m ? 1 : int'(l);
      issued = 0;
      e = 0;
      while (issued < n) begin
        exp_bz[e+1] = 1;
        if (!st[e]) begin
          if (m) exp_mk[e+1] = 1; else exp_wr[e+1] = 1;
          exp_a[e+1] = m ? '0 : REG_ADDR_W'(int'(a) + issued);
          exp_d[e+1] = d[issued*VLEN +: VLEN];
          issued++;
        end
        e++;
      end
      exp_dn[e+1] = 1;
      last = e + 2;
    end
    exp_rdy[last] = 1;

    req_valid = 1'b1; req_waddr = a; req_lmul = l; req_mask = m; req_wdata = d; stall = st[0];
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c < last) begin
        // Held-off garbage request: must not be taken while busy and must not disturb the capture.
        req_valid = 1'b1; req_waddr = REG_ADDR_W'($urandom); req_lmul = 4'($urandom);
        req_mask = 1'($urandom); req_wdata = rnd_data(); stall = st[c];
      end else begin
        req_valid = 1'b0; stall = 1'b0;
      end
      check_eq($sformatf("c%0d rdy", c),  VLEN'(req_ready), VLEN'(exp_rdy[c]));
      check_eq($sformatf("c%0d wr", c),   VLEN'(rf_wr_en), VLEN'(exp_wr[c]));
      check_eq($sformatf("c%0d mwr", c),  VLEN'(rf_mask_wr_en), VLEN'(exp_mk[c]));
      check_eq($sformatf("c%0d addr", c), VLEN'(rf_waddr), VLEN'(exp_a[c]));
      check_eq($sformatf("c%0d data", c), rf_wdata, exp_d[c]);
      check_eq($sformatf("c%0d busy", c), VLEN'(busy), VLEN'(exp_bz[c]));
      check_eq($sformatf("c%0d done", c), VLEN'(done), VLEN'(exp_dn[c]));
      check_eq($sformatf("c%0d err", c),  VLEN'(wrong_addr), VLEN'(exp_er[c]));
    end
  endtask

  task automatic reset_mid_write();
    req_valid = 1'b1; req_waddr = '0; req_lmul = 4'd8; req_mask = 1'b0;
    req_wdata = rnd_data(); stall = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst beat2 addr", VLEN'(rf_waddr), VLEN'(2));
    check_eq("rst beat2 wr", VLEN'(rf_wr_en), VLEN'(1));
    #2 reset = 1'b0;
    #1 check_quiet("rst async", 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    check_quiet("rst held", 1'b1);
    @(posedge clk);
    #1 check_quiet("rst after", 1'b1);
  endtask

  initial begin
    logic [MAX_VLEN-1:0] d;
    logic [63:0]         st;
    logic [3:0]          lm;
    reset = 1'b0; req_valid = 1'b0; req_waddr = '0; req_lmul = '0;
    req_wdata = '0; req_mask = 1'b0; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_quiet("reset", 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1 check_quiet("post reset", 1'b1);

    d = '0; d[31:0] = 32'hDEADBEEF;
    run_req(5'd5, 4'd1, 1'b0, d, '0);
    d = '0;
    for (int k = 0; k < 4; k++) d[k*VLEN +: VLEN] = VLEN'(k + 1);
    run_req(5'd8, 4'd4, 1'b0, d, '0);
    run_req(5'd6, 4'd4, 1'b0, rnd_data(), '0);
    run_req(5'd24, 4'd8, 1'b0, rnd_data(), '0);
    run_req(5'd0, 4'd3, 1'b0, rnd_data(), '0);
    d = '0; d[31:0] = 32'hDEADBEEF;
    run_req(5'd0, 4'd1, 1'b1, d, '0);
    run_req(5'd3, 4'd1, 1'b1, d, '0);
    run_req(5'd2, 4'd2, 1'b0, rnd_data(), 64'b1110);
    run_req(5'd28, 4'd8, 1'b0, rnd_data(), '0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0: lm = 4'd1;
        1: lm = 4'd2;
        2: lm = 4'd4;
        3: lm = 4'd8;
        default: lm = 4'($urandom);
      endcase
      st = '0;
      for (int b = 0; b < 16; b++) st[b] = ($urandom_range(0, 3) == 0);
      run_req(REG_ADDR_W'($urandom_range(0, 3) == 0 ? 0 : $urandom), lm,
              1'($urandom_range(0, 4) == 0), rnd_data(), st);
    end

    reset_mid_write();
    d = '0;
    for (int k = 0; k < 2; k++) d[k*VLEN +: VLEN] = VLEN'(k + 7);
    run_req(5'd30, 4'd2, 1'b0, d, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
